data_mem_controller: RTL and testbench

DATA_MEM_CONTROLLER -- requirements
Module: data_mem_controller

---
 rtl/data_mem_controller.sv | 114 +++++++++++
 tb/tb_data_mem_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_controller.sv
// data_mem_controller: MEM-stage load/store sequencer with lane steering, load extension and address-error detection.
module data_mem_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemByte,
    input  logic        MemHalf,
    input  logic        MemSignExtend,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    input  logic        M_Exception_Flush,
    input  logic        IF_Stall,
    input  logic [31:0] DataMem_In,
    input  logic        DataMem_Ready,
    output logic        DataMem_Read,
    output logic [3:0]  DataMem_Write,
    output logic [29:0] DataMem_Address,
    output logic [31:0] DataMem_Out,
    output logic [31:0] DataOut,
    output logic        M_Stall_Controller,
    output logic        EXC_AdEL,
    output logic        EXC_AdES
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_next;
    logic        is_byte, aligned, req_valid, in_access, load_done;
    logic [3:0]  req_we;
    logic [31:0] req_wdata, load_data;
    logic [15:0] load_half;
    logic [7:0]  load_byte;
    logic        lat_rd, lat_byte, lat_half, lat_se;
    logic [3:0]  lat_we;
    logic [1:0]  lat_off, cur_off;
    logic [29:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        cur_byte, cur_half, cur_se;

    assign is_byte   = MemByte & ~MemHalf;
    assign aligned   = MemHalf ? ~Address[0] : (is_byte | (Address[1:0] == 2'b00));
    assign req_valid = (MemRead | MemWrite) & ~M_Exception_Flush & aligned;
    assign EXC_AdEL  = MemRead & ~aligned;
    assign EXC_AdES  = MemWrite & ~MemRead & ~aligned;
    assign req_we    = MemRead ? 4'b0000 : is_byte ? 4'b0001 << Address[1:0] :
                       MemHalf ? (Address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign req_wdata = is_byte ? {4{DataIn[7:0]}} : MemHalf ? {2{DataIn[15:0]}} : DataIn;

    // While waiting in ACCESS the bus is driven from the captured request so it stays stable.
    assign in_access       = state == ACCESS;
    assign DataMem_Address = in_access ? lat_addr : Address[31:2];
    assign DataMem_Out     = in_access ? lat_wdata : req_wdata;
    assign cur_off         = in_access ? lat_off : Address[1:0];
    assign cur_byte        = in_access ? lat_byte : is_byte;
    assign cur_half        = in_access ? lat_half : MemHalf;
    assign cur_se          = in_access ? lat_se : MemSignExtend;

    assign load_byte = DataMem_In[{cur_off, 3'b000} +: 8];
    assign load_half = cur_off[1] ? DataMem_In[31:16] : DataMem_In[15:0];
    assign load_data = cur_byte ? {{24{cur_se & load_byte[7]}}, load_byte} :
                       cur_half ? {{16{cur_se & load_half[15]}}, load_half} : DataMem_In;
    // The read strobe is only high in an accepting state, so it also qualifies Ready.
    assign load_done = DataMem_Ready & DataMem_Read;

    always_comb begin
        state_next         = state;
        DataMem_Read       = 1'b0;
        DataMem_Write      = 4'b0000;
        M_Stall_Controller = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                DataMem_Read       = MemRead;
                DataMem_Write      = req_we;
                M_Stall_Controller = 1'b1;
                state_next         = DataMem_Ready ? DONE : ACCESS;
            end
            ACCESS: begin
                DataMem_Read       = lat_rd;
                DataMem_Write      = lat_we;
                M_Stall_Controller = 1'b1;
                state_next         = DataMem_Ready ? DONE : ACCESS;
            end
            DONE:    state_next = IF_Stall ? DONE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            DataOut   <= 32'd0;
            lat_rd    <= 1'b0;
            lat_we    <= 4'b0000;
            lat_addr  <= 30'd0;
            lat_wdata <= 32'd0;
            lat_off   <= 2'b00;
            lat_byte  <= 1'b0;
            lat_half  <= 1'b0;
            lat_se    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                lat_rd    <= MemRead;
                lat_we    <= req_we;
                lat_addr  <= Address[31:2];
                lat_wdata <= req_wdata;
                lat_off   <= Address[1:0];
                lat_byte  <= is_byte;
                lat_half  <= MemHalf;
                lat_se    <= MemSignExtend;
            end
            if (load_done) DataOut <= load_data;
        end
    end
endmodule

// File: tb/tb_data_mem_controller.sv
// tb_data_mem_controller: directed and randomized checks of data_mem_controller against a byte-level reference model.
module tb_data_mem_controller;
    logic        clock = 1'b0, reset;
    logic        MemRead, MemWrite, MemByte, MemHalf, MemSignExtend;
    logic [31:0] Address, DataIn, DataMem_In;
    logic        M_Exception_Flush, IF_Stall, DataMem_Ready;
    logic        DataMem_Read, M_Stall_Controller, EXC_AdEL, EXC_AdES;
    logic [3:0]  DataMem_Write;
    logic [29:0] DataMem_Address;
    logic [31:0] DataMem_Out, DataOut;
    int checks = 0, errors = 0;
    logic [31:0] exp_dout;

    data_mem_controller dut (
        .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .MemByte(MemByte),
        .MemHalf(MemHalf), .MemSignExtend(MemSignExtend), .Address(Address), .DataIn(DataIn),
        .M_Exception_Flush(M_Exception_Flush), .IF_Stall(IF_Stall), .DataMem_In(DataMem_In),
        .DataMem_Ready(DataMem_Ready), .DataMem_Read(DataMem_Read), .DataMem_Write(DataMem_Write),
        .DataMem_Address(DataMem_Address), .DataMem_Out(DataMem_Out), .DataOut(DataOut),
        .M_Stall_Controller(M_Stall_Controller), .EXC_AdEL(EXC_AdEL), .EXC_AdES(EXC_AdES)
    );

    always #5 clock = ~clock;

    function automatic int m_size(logic byt, logic half);
        return half ? 2 : byt ? 1 : 4;
    endfunction

    function automatic logic m_aligned(logic [31:0] addr, logic byt, logic half);
        return (addr % m_size(byt, half)) == 0;
    endfunction

    function automatic logic [3:0] m_we(logic [31:0] addr, logic byt, logic half);
        int size = m_size(byt, half);
        return 4'(((1 << size) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_mout(logic [31:0] din, logic byt, logic half);
        logic [31:0] r;
        int size = m_size(byt, half);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = din[8*(i % size) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(logic [31:0] rdata, logic [31:0] addr, logic byt, logic half, logic se);
        longint v, top;
        int size = m_size(byt, half);
        if (size == 4) return rdata;
        v = (longint'(rdata) >> (8 * (addr % 4))) & ((64'd1 << (8 * size)) - 1);
        top = 64'd1 << (8 * size - 1);
        if (se && (v & top) != 0) v = v - 2 * top;
        return 32'(v);
    endfunction

    task automatic set_idle();
        MemRead = 0; MemWrite = 0; MemByte = 0; MemHalf = 0; MemSignExtend = 0;
        Address = 0; DataIn = 0; M_Exception_Flush = 0; DataMem_Ready = 0;
    endtask

    // Presents one request, pulses Ready after lat cycles, observes through the DONE cycle.
    task automatic do_access(input logic rd, wr, byt, half, se, input logic [31:0] addr, din, rdata,
                             input int lat, output int n_rd, n_wr, n_stall, output logic [3:0] we_seen,
                             output logic [31:0] mout_seen, output logic [29:0] maddr_seen, output logic stable);
        n_rd = 0; n_wr = 0; n_stall = 0; we_seen = 0; mout_seen = 0; maddr_seen = 0; stable = 1;
        MemRead = rd; MemWrite = wr; MemByte = byt; MemHalf = half; MemSignExtend = se;
        Address = addr; DataIn = din; DataMem_In = rdata;
        for (int c = 0; c <= lat + 1; c++) begin
            DataMem_Ready = (c == lat);
            if (c == lat + 1) begin MemRead = 0; MemWrite = 0; end
            @(negedge clock);
            if (DataMem_Read) n_rd++;
            if (M_Stall_Controller) n_stall++;
            if (DataMem_Write != 0) begin
                if (n_wr > 0 && (we_seen !== DataMem_Write || mout_seen !== DataMem_Out || maddr_seen !== DataMem_Address)) stable = 0;
                n_wr++; we_seen = DataMem_Write; mout_seen = DataMem_Out; maddr_seen = DataMem_Address;
            end
            @(posedge clock); #1;
        end
        DataMem_Ready = 0;
    endtask

    task automatic test_reset();
        reset = 1; set_idle(); IF_Stall = 0; DataMem_In = 0;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        checks++; if (DataMem_Read !== 1'b0) begin errors++; $display("FAIL reset_read got=%b exp=0", DataMem_Read); end
        checks++; if (DataMem_Write !== 4'b0000) begin errors++; $display("FAIL reset_write got=%b exp=0000", DataMem_Write); end
        checks++; if (M_Stall_Controller !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", M_Stall_Controller); end
        checks++; if (DataOut !== 32'd0) begin errors++; $display("FAIL reset_dataout got=%h exp=0", DataOut); end
        @(posedge clock); #1;
        exp_dout = 0;
    endtask

    task automatic test_word_load();
        int n_rd, n_wr, n_st; logic [3:0] we; logic [31:0] mo; logic [29:0] ma; logic st;
        do_access(1, 0, 0, 0, 0, 32'h100, 0, 32'hDEADBEEF, 3, n_rd, n_wr, n_st, we, mo, ma, st);
        checks++; if (n_rd !== 4) begin errors++; $display("FAIL lw_read_cycles got=%0d exp=4", n_rd); end
        checks++; if (n_st !== 4) begin errors++; $display("FAIL lw_stall_cycles got=%0d exp=4", n_st); end
        checks++; if (n_wr !== 0) begin errors++; $display("FAIL lw_write_cycles got=%0d exp=0", n_wr); end
        checks++; if (DataOut !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_dataout got=%h exp=deadbeef", DataOut); end
        do_access(1, 0, 0, 0, 0, 32'h104, 0, 32'h0BADF00D, 0, n_rd, n_wr, n_st, we, mo, ma, st);
        checks++; if (n_st !== 1) begin errors++; $display("FAIL lw_min_latency_stall got=%0d exp=1", n_st); end
        checks++; if (n_rd !== 1) begin errors++; $display("FAIL lw_min_latency_read got=%0d exp=1", n_rd); end
        checks++; if (DataOut !== 32'h0BADF00D) begin errors++; $display("FAIL lw_min_latency_dataout got=%h exp=0badf00d", DataOut); end
    endtask

    task automatic test_byte_load();
        int n_rd, n_wr, n_st; logic [3:0] we; logic [31:0] mo; logic [29:0] ma; logic st;
        do_access(1, 0, 1, 0, 1, 32'h103, 0, 32'h80FFFFFF, 1, n_rd, n_wr, n_st, we, mo, ma, st);
        checks++; if (DataOut !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed got=%h exp=ffffff80", DataOut); end
        do_access(1, 0, 1, 0, 0, 32'h103, 0, 32'h80FFFFFF, 2, n_rd, n_wr, n_st, we, mo, ma, st);
        checks++; if (DataOut !== 32'h00000080) begin errors++; $display("FAIL lbu got=%h exp=00000080", DataOut); end
    endtask

    task automatic test_half_store();
        int n_rd, n_wr, n_st; logic [3:0] we; logic [31:0] mo; logic [29:0] ma; logic st;
        do_access(0, 1, 0, 1, 0, 32'h202, 32'hABCD1234, 0, 2, n_rd, n_wr, n_st, we, mo, ma, st);
        checks++; if (we !== 4'b1100) begin errors++; $display("FAIL sh_write got=%b exp=1100", we); end
        checks++; if (mo !== 32'h12341234) begin errors++; $display("FAIL sh_dataout_bus got=%h exp=12341234", mo); end
        checks++; if (ma !== 30'h80) begin errors++; $display("FAIL sh_address got=%h exp=80", ma); end
        checks++; if (n_wr !== 3 || !st) begin errors++; $display("FAIL sh_write_hold got=%0d/%b exp=3/1", n_wr, st); end
        checks++; if (n_rd !== 0) begin errors++; $display("FAIL sh_no_read got=%0d exp=0", n_rd); end
    endtask

    task automatic test_misaligned();
        MemRead = 1; Address = 32'h101;
        @(negedge clock);
        checks++; if ({EXC_AdEL, DataMem_Read, M_Stall_Controller} !== 3'b100) begin errors++; $display("FAIL lw_misaligned got=%b exp=100", {EXC_AdEL, DataMem_Read, M_Stall_Controller}); end
        @(posedge clock); #1;
        set_idle(); MemWrite = 1; MemHalf = 1; Address = 32'h001; DataIn = 32'h5555;
        @(negedge clock);
        checks++; if ({EXC_AdES, DataMem_Write, M_Stall_Controller} !== 6'b100000) begin errors++; $display("FAIL sh_misaligned got=%b exp=100000", {EXC_AdES, DataMem_Write, M_Stall_Controller}); end
        @(posedge clock); #1;
        set_idle(); MemRead = 1; Address = 32'h100; M_Exception_Flush = 1;
        @(negedge clock);
        checks++; if ({EXC_AdEL, DataMem_Read, M_Stall_Controller} !== 3'b000) begin errors++; $display("FAIL flush got=%b exp=000", {EXC_AdEL, DataMem_Read, M_Stall_Controller}); end
        @(posedge clock); #1;
        set_idle();
    endtask

    task automatic test_if_stall();
        int n_rd, n_wr, n_st; logic [3:0] we; logic [31:0] mo; logic [29:0] ma; logic st;
        IF_Stall = 1;
        do_access(1, 0, 0, 0, 0, 32'h300, 0, 32'h13579BDF, 1, n_rd, n_wr, n_st, we, mo, ma, st);
        MemRead = 1; Address = 32'h300;
        for (int i = 0; i < 5; i++) begin
            DataMem_Ready = (i == 2); DataMem_In = 32'hFFFF0000;
            @(negedge clock);
            checks++; if ({DataMem_Read, M_Stall_Controller} !== 2'b00) begin errors++; $display("FAIL ifstall_hold%0d got=%b exp=00", i, {DataMem_Read, M_Stall_Controller}); end
            checks++; if (DataOut !== 32'h13579BDF) begin errors++; $display("FAIL ifstall_dataout%0d got=%h exp=13579bdf", i, DataOut); end
            @(posedge clock); #1;
        end
        IF_Stall = 0; set_idle();
        @(posedge clock); #1;
        checks++; if (n_rd !== 2) begin errors++; $display("FAIL ifstall_single_issue got=%0d exp=2", n_rd); end
    endtask

    task automatic test_reset_mid_access();
        MemRead = 1; Address = 32'h400; DataMem_Ready = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if ({DataMem_Read, M_Stall_Controller} !== 2'b11) begin errors++; $display("FAIL access_wait got=%b exp=11", {DataMem_Read, M_Stall_Controller}); end
        @(posedge clock); #1;
        reset = 1; set_idle();
        @(posedge clock); #1;
        reset = 0; DataMem_Ready = 1; DataMem_In = 32'hFFFFFFFF;
        @(negedge clock);
        checks++; if ({DataMem_Read, DataMem_Write, M_Stall_Controller} !== 6'b0) begin errors++; $display("FAIL rst_access_strobes got=%b exp=000000", {DataMem_Read, DataMem_Write, M_Stall_Controller}); end
        checks++; if (DataOut !== 32'd0) begin errors++; $display("FAIL rst_access_dataout got=%h exp=0", DataOut); end
        @(posedge clock); #1;
        DataMem_Ready = 0;
        @(negedge clock);
        checks++; if ({DataOut, M_Stall_Controller} !== 33'd0) begin errors++; $display("FAIL late_ready_ignored got=%h/%b exp=0/0", DataOut, M_Stall_Controller); end
        @(posedge clock); #1;
        exp_dout = 0;
    endtask

    task automatic test_random();
        int n_rd, n_wr, n_st, lat, size; logic [3:0] we; logic [31:0] mo; logic [29:0] ma; logic st;
        logic rd, wr, byt, half, se; logic [31:0] addr, din, rdata;
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 2))
                0: begin rd = 1; wr = 0; end
                1: begin rd = 0; wr = 1; end
                default: begin rd = 1; wr = 1; end
            endcase
            byt = 1'($urandom); half = 1'($urandom); se = 1'($urandom);
            addr = $urandom; din = $urandom; rdata = $urandom; lat = $urandom_range(0, 3);
            size = m_size(byt, half);
            if ($urandom_range(0, 3) != 0) addr = addr - (addr % size);
            if (!m_aligned(addr, byt, half)) begin
                MemRead = rd; MemWrite = wr; MemByte = byt; MemHalf = half; Address = addr;
                @(negedge clock);
                checks++; if ({EXC_AdEL, EXC_AdES, DataMem_Read, DataMem_Write, M_Stall_Controller} !== {rd, ~rd, 6'b0})
                    begin errors++; $display("FAIL rnd_misaligned it=%0d got=%b exp=%b", it, {EXC_AdEL, EXC_AdES, DataMem_Read, DataMem_Write, M_Stall_Controller}, {rd, ~rd, 6'b0}); end
                @(posedge clock); #1;
                set_idle();
            end else begin
                do_access(rd, wr, byt, half, se, addr, din, rdata, lat, n_rd, n_wr, n_st, we, mo, ma, st);
                checks++; if (n_st !== lat + 1) begin errors++; $display("FAIL rnd_stall it=%0d got=%0d exp=%0d", it, n_st, lat + 1); end
                if (rd) begin
                    exp_dout = m_load(rdata, addr, byt, half, se);
                    checks++; if (n_rd !== lat + 1 || n_wr !== 0) begin errors++; $display("FAIL rnd_load_strobes it=%0d got=%0d/%0d exp=%0d/0", it, n_rd, n_wr, lat + 1); end
                end else begin
                    checks++; if (n_wr !== lat + 1 || n_rd !== 0 || !st) begin errors++; $display("FAIL rnd_store_strobes it=%0d got=%0d/%0d/%b exp=%0d/0/1", it, n_wr, n_rd, st, lat + 1); end
                    checks++; if (we !== m_we(addr, byt, half)) begin errors++; $display("FAIL rnd_store_we it=%0d got=%b exp=%b", it, we, m_we(addr, byt, half)); end
                    checks++; if (mo !== m_mout(din, byt, half)) begin errors++; $display("FAIL rnd_store_data it=%0d got=%h exp=%h", it, mo, m_mout(din, byt, half)); end
                    checks++; if (ma !== addr[31:2]) begin errors++; $display("FAIL rnd_store_addr it=%0d got=%h exp=%h", it, ma, addr[31:2]); end
                end
                checks++; if (DataOut !== exp_dout) begin errors++; $display("FAIL rnd_dataout it=%0d got=%h exp=%h", it, DataOut, exp_dout); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_if_stall();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
